// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the unified-memory access controller: the
// sequencer state encoding, the request source tags and the default
// address/data widths.
// Optional feature macro used by the controller: MEM_CTRL_WRITE_VERIFY_EN.
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   // Source tag: which requester owns the access in flight
   localparam logic SRC_FETCH = 1'b0;
   localparam logic SRC_DATA  = 1'b1;

   // The VF_* encodings are only reached when write-verify is compiled in
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_VF_ISSUE = 3'd4,
      ST_VF_WAIT  = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

endpackage

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
// Combinational fixed-priority select between the load/store path and the
// instruction-fetch path. The data path always wins when both are pending.
// Ports:
//   if_req  in  fetch request
//   d_req   in  data request
//   grant   out some request is pending
//   src     out winning source (SRC_DATA / SRC_FETCH)
// ---------------------------------------------------------------------------
module mem_req_arbiter
   import mem_ctrl_pkg::*;
(
   input  logic if_req,
   input  logic d_req,
   output logic grant,
   output logic src
);

   // Fixed priority: data over fetch
   always_comb begin
      grant = 1'b0;
      src   = SRC_FETCH;
      if (d_req) begin
         grant = 1'b1;
         src   = SRC_DATA;
      end else if (if_req) begin
         grant = 1'b1;
         src   = SRC_FETCH;
      end else begin
         grant = 1'b0;
         src   = SRC_FETCH;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Initiator side of the single-port unified memory. Arbitrates fetch vs
// load/store requests, drives the memory's synchronous enable/writeEnable/
// address/writeData port and returns read data with a one-cycle ack.
// All outputs are registered.
// Ports:
//   clock, reset            system clock, async active-high reset
//   if_req/if_addr          fetch request (held until if_ack)
//   if_ack/if_rdata         fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request (held until d_ack)
//   d_ack/d_rdata           data completion pulse and load result
//   mem_*                   memory port (1-cycle read latency)
//   busy                    state is not IDLE
//   verify_err              sticky write-verify mismatch
// Optional feature: define MEM_CTRL_WRITE_VERIFY_EN to read back every store
// and flag mismatches on verify_err; otherwise verify_err stays 0.
// ---------------------------------------------------------------------------
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_enable,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              busy,
   output logic              verify_err
);

   state_t state_r;
   logic   tag_r;
   logic   grant_s;
   logic   src_s;

   mem_req_arbiter u_arb (
      .if_req (if_req),
      .d_req  (d_req),
      .grant  (grant_s),
      .src    (src_s)
   );

   // Access sequencer; every output is produced here as a register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r          <= ST_IDLE;
         tag_r            <= SRC_FETCH;
         if_ack           <= 1'b0;
         if_rdata         <= {DATA_W{1'b0}};
         d_ack            <= 1'b0;
         d_rdata          <= {DATA_W{1'b0}};
         mem_enable       <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_address      <= {ADDR_W{1'b0}};
         mem_write_data   <= {DATA_W{1'b0}};
         busy             <= 1'b0;
         verify_err       <= 1'b0;
      end else begin
         // Acks are single-cycle pulses unless a state raises them
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  tag_r      <= src_s;
                  mem_enable <= 1'b1;
                  busy       <= 1'b1;
                  if (src_s == SRC_DATA) begin
                     mem_address <= d_addr;
                     if (d_we) begin
                        mem_write_enable <= 1'b1;
                        mem_write_data   <= d_wdata;
                        state_r          <= ST_WR_ISSUE;
                     end else begin
                        mem_write_enable <= 1'b0;
                        state_r          <= ST_RD_ISSUE;
                     end
                  end else begin
                     mem_address      <= if_addr;
                     mem_write_enable <= 1'b0;
                     state_r          <= ST_RD_ISSUE;
                  end
               end else begin
                  mem_enable       <= 1'b0;
                  mem_write_enable <= 1'b0;
                  busy             <= 1'b0;
                  state_r          <= ST_IDLE;
               end
            end
            ST_RD_ISSUE: begin
               mem_enable <= 1'b0;
               state_r    <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               // Memory read data became valid on the previous edge
               if (tag_r == SRC_DATA) begin
                  d_rdata <= mem_read_data;
                  d_ack   <= 1'b1;
               end else begin
                  if_rdata <= mem_read_data;
                  if_ack   <= 1'b1;
               end
               state_r <= ST_DONE;
            end
            ST_WR_ISSUE: begin
               mem_write_enable <= 1'b0;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
               // Keep enable high: next cycle is the read-back of the same address
               mem_enable <= 1'b1;
               state_r    <= ST_VF_ISSUE;
`else
               mem_enable <= 1'b0;
               d_ack      <= 1'b1;
               state_r    <= ST_DONE;
`endif
            end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
            ST_VF_ISSUE: begin
               mem_enable <= 1'b0;
               state_r    <= ST_VF_WAIT;
            end
            ST_VF_WAIT: begin
               // mem_write_data still holds the stored word
               if (mem_read_data != mem_write_data) begin
                  verify_err <= 1'b1;
               end else begin
                  verify_err <= verify_err;
               end
               d_ack   <= 1'b1;
               state_r <= ST_DONE;
            end
`endif
            ST_DONE: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               mem_enable       <= 1'b0;
               mem_write_enable <= 1'b0;
               busy             <= 1'b0;
               state_r          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed self-checking bench for mem_access_ctrl with a small behavioural
// memory (1-cycle read latency, backdoor preload, optional read corruption).
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = 16'h0000;
   logic        if_ack;
   logic [15:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = 16'h0000;
   logic [15:0] d_wdata = 16'h0000;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic        mem_enable;
   logic        mem_write_enable;
   logic [15:0] mem_address;
   logic [15:0] mem_write_data;
   logic [15:0] mem_read_data;
   logic        busy;
   logic        verify_err;

   // Backdoor preload port and read corruption control for the memory model
   logic        bd_we = 1'b0;
   logic [7:0]  bd_addr = 8'h00;
   logic [15:0] bd_data = 16'h0000;
   logic        corrupt = 1'b0;

   logic [15:0] mem_model [0:255];

   int pass_cnt = 0;
   int total_cnt = 0;
   int if_ack_cnt = 0;
   int d_ack_cnt = 0;
   int we_cnt = 0;
   int snap_a;
   int snap_b;

   always #5 clock = ~clock;

   mem_access_ctrl dut (
      .clock            (clock),
      .reset            (reset),
      .if_req           (if_req),
      .if_addr          (if_addr),
      .if_ack           (if_ack),
      .if_rdata         (if_rdata),
      .d_req            (d_req),
      .d_we             (d_we),
      .d_addr           (d_addr),
      .d_wdata          (d_wdata),
      .d_ack            (d_ack),
      .d_rdata          (d_rdata),
      .mem_enable       (mem_enable),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data),
      .busy             (busy),
      .verify_err       (verify_err)
   );

   // Memory model: synchronous write, registered read
   always @(posedge clock) begin
      if (bd_we) begin
         mem_model[bd_addr] <= bd_data;
      end else if (mem_enable) begin
         if (mem_write_enable) begin
            mem_model[mem_address[7:0]] <= mem_write_data;
         end else begin
            mem_read_data <= mem_model[mem_address[7:0]] ^ {15'd0, corrupt};
         end
      end
   end

   // Event counters for acks and write strobes
   always @(negedge clock) begin
      if (if_ack === 1'b1) if_ack_cnt++;
      if (d_ack === 1'b1) d_ack_cnt++;
      if (mem_write_enable === 1'b1) we_cnt++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] v);
      bd_we = 1'b1;
      bd_addr = a;
      bd_data = v;
      tick();
      bd_we = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
      check("rst_rdata", {if_rdata, d_rdata}, 32'd0);
      check("rst_addr", {16'd0, mem_address}, 32'd0);
      check("rst_verify_err", {31'd0, verify_err}, 32'd0);
      reset = 1'b0;
      preload(8'h02, 16'h1234);
      preload(8'h01, 16'hBEEF);
      preload(8'h14, 16'h5A5A);
      preload(8'h17, 16'h0777);

      // Fetch from 0x0002
      snap_a = we_cnt;
      if_req = 1'b1;
      if_addr = 16'h0002;
      tick();
      check("fetch_issue_en", {31'd0, mem_enable}, 32'd1);
      check("fetch_issue_addr", {16'd0, mem_address}, 32'h0002);
      check("fetch_busy", {31'd0, busy}, 32'd1);
      tick();
      check("fetch_wait_en", {31'd0, mem_enable}, 32'd0);
      check("fetch_wait_noack", {31'd0, if_ack}, 32'd0);
      tick();
      check("fetch_ack", {31'd0, if_ack}, 32'd1);
      check("fetch_rdata", {16'd0, if_rdata}, 32'h1234);
      if_req = 1'b0;
      tick();
      check("fetch_ack_pulse", {31'd0, if_ack}, 32'd0);
      check("fetch_idle_busy", {31'd0, busy}, 32'd0);
      check("fetch_no_write", we_cnt, snap_a);

      // Store 0xFA2D to 0x000F
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 16'h000F;
      d_wdata = 16'hFA2D;
      tick();
      check("store_issue", {mem_enable, mem_write_enable, 14'd0, mem_address}, {2'b11, 14'd0, 16'h000F});
      check("store_wdata", {16'd0, mem_write_data}, 32'hFA2D);
      check("store_noack_early", {31'd0, d_ack}, 32'd0);
      tick();
`ifdef MEM_CTRL_WRITE_VERIFY_EN
      check("store_vf_issue", {mem_enable, mem_write_enable}, 32'd2);
      tick();
      tick();
`endif
      check("store_ack", {31'd0, d_ack}, 32'd1);
      check("store_we_low", {31'd0, mem_write_enable}, 32'd0);
      d_req = 1'b0;
      tick();
      check("store_done_idle", {31'd0, busy}, 32'd0);

      // Load back 0x000F
      d_req = 1'b1;
      d_we = 1'b0;
      tick();
      check("load_issue_we", {mem_enable, mem_write_enable}, 32'd2);
      tick();
      tick();
      check("load_ack", {31'd0, d_ack}, 32'd1);
      check("load_rdata", {16'd0, d_rdata}, 32'hFA2D);
      check("load_if_rdata_held", {16'd0, if_rdata}, 32'h1234);
      d_req = 1'b0;
      tick();

      // Contention: data first, fetch four cycles later
      if_req = 1'b1;
      if_addr = 16'h0001;
      d_req = 1'b1;
      d_addr = 16'h0014;
      tick();
      check("cont_data_first", {16'd0, mem_address}, 32'h0014);
      tick();
      tick();
      check("cont_acks_1", {30'd0, d_ack, if_ack}, 32'd2);
      check("cont_d_rdata", {16'd0, d_rdata}, 32'h5A5A);
      d_req = 1'b0;
      tick();
      tick();
      check("cont_fetch_addr", {16'd0, mem_address}, 32'h0001);
      tick();
      tick();
      check("cont_acks_2", {30'd0, d_ack, if_ack}, 32'd1);
      check("cont_if_rdata", {16'd0, if_rdata}, 32'hBEEF);
      if_req = 1'b0;
      tick();

      // Held request: second access restarts from IDLE, one ack each
      snap_a = d_ack_cnt;
      d_req = 1'b1;
      d_addr = 16'h0014;
      tick();
      tick();
      tick();
      check("held_ack1", {31'd0, d_ack}, 32'd1);
      d_addr = 16'h0017;
      tick();
      check("held_done_noack", {31'd0, d_ack}, 32'd0);
      check("held_idle", {31'd0, busy}, 32'd0);
      tick();
      check("held_reissue_addr", {16'd0, mem_address}, 32'h0017);
      tick();
      tick();
      check("held_ack2", {31'd0, d_ack}, 32'd1);
      check("held_rdata2", {16'd0, d_rdata}, 32'h0777);
      d_req = 1'b0;
      tick();
      check("held_ack_count", d_ack_cnt - snap_a, 32'd2);

      // Reset during RD_WAIT
      if_req = 1'b1;
      if_addr = 16'h0002;
      tick();
      tick();
      snap_b = if_ack_cnt;
      reset = 1'b1;
      #1;
      check("midrst_outputs", {busy, mem_enable, mem_write_enable, if_ack, d_ack, 11'd0, mem_address}, 32'd0);
      check("midrst_rdata", {if_rdata, d_rdata}, 32'd0);
      tick();
      reset = 1'b0;
      check("midrst_no_ack", if_ack_cnt, snap_b);
      tick();
      tick();
      tick();
      check("midrst_refetch_ack", {31'd0, if_ack}, 32'd1);
      check("midrst_refetch_data", {16'd0, if_rdata}, 32'h1234);
      if_req = 1'b0;
      tick();

      // Store whose read-back is corrupted (0x9999 reads back as 0x9998)
      corrupt = 1'b1;
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 16'h0020;
      d_wdata = 16'h9999;
      tick();
      tick();
`ifdef MEM_CTRL_WRITE_VERIFY_EN
      check("vf_err_before_ack", {31'd0, verify_err}, 32'd0);
      tick();
      tick();
      check("vf_ack", {31'd0, d_ack}, 32'd1);
      check("vf_err_set", {31'd0, verify_err}, 32'd1);
`else
      check("nv_ack", {31'd0, d_ack}, 32'd1);
      check("nv_err_tied", {31'd0, verify_err}, 32'd0);
`endif
      corrupt = 1'b0;
      d_wdata = 16'h1111;
      tick();
      tick();
`ifdef MEM_CTRL_WRITE_VERIFY_EN
      tick();
      tick();
      tick();
      check("vf_err_sticky", {31'd0, verify_err}, 32'd1);
`else
      tick();
      check("nv_err_still0", {31'd0, verify_err}, 32'd0);
`endif
      d_req = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("err_cleared_by_reset", {31'd0, verify_err}, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
